frame_capture: RTL

FRAME_CAPTURE -- requirements
Module: frame_capture

---
 rtl/frame_capture_if.sv | 28 ++
 rtl/frame_capture.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/frame_capture_if.sv
// Video-in / buffer-write bundle for frame_capture.
// master = capture engine, slave = video source plus buffer/status sink.
interface frame_capture_if #(
  parameter int NUM_FRAMES  = 7,
  parameter int PIXEL_WIDTH = 8
);
  logic [23:0]            vid_pData;
  logic                   vid_pVDE;
  logic                   vid_pHSync;
  logic                   vid_pVSync;
  logic                   capture_en;
  logic [NUM_FRAMES-1:0]  wr_we;
  logic [16:0]            wr_addr;
  logic [PIXEL_WIDTH-1:0] wr_data;
  logic [3:0]             cur_frame;
  logic                   frame_valid;
  logic                   frame_done;
  logic                   frame_err;

  modport master (
    input  vid_pData, vid_pVDE, vid_pHSync, vid_pVSync, capture_en,
    output wr_we, wr_addr, wr_data, cur_frame, frame_valid, frame_done, frame_err
  );
  modport slave (
    output vid_pData, vid_pVDE, vid_pHSync, vid_pVSync, capture_en,
    input  wr_we, wr_addr, wr_data, cur_frame, frame_valid, frame_done, frame_err
  );
endinterface

// File: rtl/frame_capture.sv
// Captures active video into NUM_FRAMES rotating buffers, committing a frame on each VSync fall.
// Define FRAME_CAPTURE_GRAY_EN to store (R+2G+B)/4 instead of the G channel.
module frame_capture #(
  parameter int IMAGE_WIDTH  = 316,
  parameter int IMAGE_HEIGHT = 252,
  parameter int NUM_FRAMES   = 7,
  parameter int PIXEL_WIDTH  = 8
) (
  input logic             PixelClk,
  input logic             aRst_n,
  frame_capture_if.master vif
);
  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

  localparam logic [10:0]           W_X    = 11'(IMAGE_WIDTH);
  localparam logic [9:0]            H_Y    = 10'(IMAGE_HEIGHT);
  localparam logic [16:0]           W_A    = 17'(IMAGE_WIDTH);
  localparam logic [3:0]            F_LAST = 4'(NUM_FRAMES - 1);
  localparam logic [NUM_FRAMES-1:0] WE_ONE = NUM_FRAMES'(1);

  state_t                 state_q, state_d;
  logic                   vs_q, vde_q;
  logic [10:0]            x_q, x_d;
  logic [9:0]             y_q, y_d;
  logic [16:0]            base_q, base_d;
  logic [3:0]             wr_frame_q, wr_frame_d, cur_q, cur_d;
  logic                   valid_q, valid_d, done_q, done_d, err_q, err_d;
  logic [NUM_FRAMES-1:0]  we_q, we_d;
  logic [16:0]            addr_q, addr_d;
  logic [PIXEL_WIDTH-1:0] data_q, data_d;
  logic [7:0]             pix;
  logic                   vs_fall, vde_fall, wr_en;
  logic                   unused_sig;

  assign vs_fall  = vs_q & ~vif.vid_pVSync;
  assign vde_fall = vde_q & ~vif.vid_pVDE;
  assign wr_en    = (state_q == CAPTURE) && vif.vid_pVDE && (x_q < W_X) && (y_q < H_Y);

`ifdef FRAME_CAPTURE_GRAY_EN
  logic [9:0] sum;
  assign sum = {2'b00, vif.vid_pData[23:16]} + {1'b0, vif.vid_pData[7:0], 1'b0}
             + {2'b00, vif.vid_pData[15:8]};
  assign pix = sum[9:2];
  assign unused_sig = vif.vid_pHSync;
`else
  assign pix = vif.vid_pData[7:0];
  assign unused_sig = ^{vif.vid_pHSync, vif.vid_pData[23:8]};
`endif

  always_ff @(posedge PixelClk or negedge aRst_n) begin
    if (!aRst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Dropping capture_en only takes effect at a frame boundary, so frames are never truncated.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (vif.capture_en) state_d = WAIT_VS;
      WAIT_VS: if (vs_fall) state_d = CAPTURE;
      CAPTURE: if (vs_fall && !vif.capture_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d        = '0;
    y_d        = '0;
    base_d     = '0;
    wr_frame_d = wr_frame_q;
    cur_d      = cur_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    we_d       = '0;
    addr_d     = addr_q;
    data_d     = data_q;
    if (wr_en) begin
      we_d   = WE_ONE << wr_frame_q;
      addr_d = base_q + {6'd0, x_q};
      data_d = PIXEL_WIDTH'(pix);
    end
    if (state_q == CAPTURE) begin
      x_d    = x_q;
      y_d    = y_q;
      base_d = base_q;
      if (vs_fall) begin
        x_d    = '0;
        y_d    = '0;
        base_d = '0;
        // wr_frame moves past the committed buffer, so cur_frame is never overwritten.
        if (y_q >= H_Y) begin
          done_d     = 1'b1;
          cur_d      = wr_frame_q;
          valid_d    = 1'b1;
          wr_frame_d = (wr_frame_q == F_LAST) ? 4'd0 : wr_frame_q + 4'd1;
        end else begin
          err_d = 1'b1;
        end
      end else if (vif.vid_pVDE) begin
        if (x_q != '1) x_d = x_q + 11'd1;
      end else if (vde_fall) begin
        x_d = '0;
        if (y_q != '1) y_d = y_q + 10'd1;
        if (y_q < H_Y) base_d = base_q + W_A;
      end
    end
  end

  always_ff @(posedge PixelClk or negedge aRst_n) begin
    if (!aRst_n) begin
      vs_q       <= 1'b0;
      vde_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      base_q     <= '0;
      wr_frame_q <= '0;
      cur_q      <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      vs_q       <= vif.vid_pVSync;
      vde_q      <= vif.vid_pVDE;
      x_q        <= x_d;
      y_q        <= y_d;
      base_q     <= base_d;
      wr_frame_q <= wr_frame_d;
      cur_q      <= cur_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign vif.wr_we       = we_q;
  assign vif.wr_addr     = addr_q;
  assign vif.wr_data     = data_q;
  assign vif.cur_frame   = cur_q;
  assign vif.frame_valid = valid_q;
  assign vif.frame_done  = done_q;
  assign vif.frame_err   = err_q;
endmodule
